// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - slot encoding and seven-segment constants for the BCD display mux
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package bcd_pkg;

   typedef enum logic {
      S_UNITS = 1'b0,
      S_TENS  = 1'b1
   } slot_e;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_ERR   = 7'h06;

   localparam logic [6:0] SEG_0 = 7'h40;
   localparam logic [6:0] SEG_1 = 7'h79;
   localparam logic [6:0] SEG_2 = 7'h24;
   localparam logic [6:0] SEG_3 = 7'h30;
   localparam logic [6:0] SEG_4 = 7'h19;
   localparam logic [6:0] SEG_5 = 7'h12;
   localparam logic [6:0] SEG_6 = 7'h02;
   localparam logic [6:0] SEG_7 = 7'h78;
   localparam logic [6:0] SEG_8 = 7'h00;
   localparam logic [6:0] SEG_9 = 7'h10;

endpackage

// File: rtl/bcd_to_seg.sv
// rtl/bcd_to_seg.sv - combinational BCD digit to active-low seven-segment decoder
// Ports:
//   bcd_i : 4-bit digit
//   seg_o : active-low {g,f,e,d,c,b,a}; codes 10-15 show "E"
module bcd_to_seg
   import bcd_pkg::*;
(
   input  logic [3:0] bcd_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_ERR;
      case (bcd_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: seg_o = SEG_ERR;
      endcase
   end

endmodule

// File: rtl/bcd_display_mux.sv
// rtl/bcd_display_mux.sv - two-digit time-multiplexed seven-segment driver for a BCD sum
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   load         : capture strobe for bcd1/bcd0
//   bcd1, bcd0   : tens / units digits
//   blank_lz     : blank the tens digit when it is zero
//   seg          : active-low segments {g,f,e,d,c,b,a}, registered
//   an           : active-low digit enables, an[0]=units, an[1]=tens, registered
module bcd_display_mux
   import bcd_pkg::*;
#(
   parameter int REFRESH_DIV = 50000
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [3:0] bcd1,
   input  logic [3:0] bcd0,
   input  logic       blank_lz,
   output logic [6:0] seg,
   output logic [1:0] an
);

   localparam int               CNT_W   = $clog2(REFRESH_DIV);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   slot_e            state_q, state_d;
   logic [3:0]       d1_q, d1_d;
   logic [3:0]       d0_q, d0_d;
   logic [6:0]       seg_q, seg_d;
   logic [1:0]       an_q, an_d;
   logic             tick;
   logic [3:0]       digit;
   logic [6:0]       digit_seg;

   // One shared decoder; the slot picks which captured digit feeds it.
   assign digit = (state_q == S_TENS) ? d1_q : d0_q;

   bcd_to_seg u_dec (
      .bcd_i (digit),
      .seg_o (digit_seg)
   );

   assign tick = (cnt_q == CNT_MAX);

   always_comb begin
      cnt_d   = tick ? '0 : cnt_q + CNT_W'(1);
      state_d = state_q;
      if (tick) begin
         state_d = (state_q == S_UNITS) ? S_TENS : S_UNITS;
      end
      d1_d = load ? bcd1 : d1_q;
      d0_d = load ? bcd0 : d0_q;

      // Outputs follow the current slot and digits, landing one edge later.
      seg_d = digit_seg;
      an_d  = 2'b10;
      if (state_q == S_TENS) begin
         if (blank_lz && (d1_q == 4'd0)) begin
            seg_d = SEG_BLANK;
            an_d  = 2'b11;
         end else begin
            an_d  = 2'b01;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         state_q <= S_UNITS;
         d1_q    <= 4'd0;
         d0_q    <= 4'd0;
         seg_q   <= SEG_BLANK;
         an_q    <= 2'b11;
      end else begin
         cnt_q   <= cnt_d;
         state_q <= state_d;
         d1_q    <= d1_d;
         d0_q    <= d0_d;
         seg_q   <= seg_d;
         an_q    <= an_d;
      end
   end

   assign seg = seg_q;
   assign an  = an_q;

endmodule

// File: doc/bcd_display_mux.md
BCD_DISPLAY_MUX -- requirements
Module: bcd_display_mux

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk is the only clock, and rst asserts asynchronously, active-high.
REQ-002 The block SHALL have parameter REFRESH_DIV, default 50000: clk cycles per digit slot, legal values 2 or more.
REQ-003 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port load, input, 1 bit: capture strobe for bcd1/bcd0, sampled on the rising edge of clk.
REQ-006 The block SHALL have port bcd1, input, 4 bits: tens digit from the upstream BCD adder.
REQ-007 The block SHALL have port bcd0, input, 4 bits: units digit from the upstream BCD adder.
REQ-008 The block SHALL have port blank_lz, input, 1 bit: leading-zero blanking enable.
REQ-009 The block SHALL have port seg, output, 7 bits: active-low segments {g,f,e,d,c,b,a}, registered.
REQ-010 The block SHALL have port an, output, 2 bits: active-low digit enables, an[0] = units, an[1] = tens, registered.

Function
REQ-011 When load=1 at a clk edge, the block SHALL capture bcd1 and bcd0 into the internal registers d1_q and d0_q; when load=0, d1_q and d0_q SHALL hold.
REQ-012 The prescaler cnt SHALL count 0 to REFRESH_DIV-1 and wrap to 0; tick SHALL be high when cnt = REFRESH_DIV-1.
REQ-013 The FSM SHALL have two states, S_UNITS and S_TENS: on tick, S_UNITS goes to S_TENS and S_TENS goes to S_UNITS; otherwise the state holds.
REQ-014 Every cycle, seg and an SHALL register the current state's decode, giving a 1-cycle latency from a state or d*_q change to the outputs.
REQ-015 In S_UNITS, an SHALL be 2'b10 and seg SHALL be decode(d0_q).
REQ-016 In S_TENS, an SHALL be 2'b01 and seg SHALL be decode(d1_q), except as REQ-017 requires.
REQ-017 In S_TENS with blank_lz=1 and d1_q=0, an SHALL be 2'b11 and seg SHALL be 7'h7F.
REQ-018 decode SHALL produce: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
REQ-019 decode of any invalid digit (10-15) SHALL produce "E", 7'h06; the block SHALL NOT saturate or otherwise correct it.
REQ-020 When load and tick occur in the same cycle, both SHALL take effect: the new slot shows the newly loaded value one cycle later.
REQ-021 Changes to blank_lz SHALL take effect on the next clk edge, with no capture needed.

Reset
REQ-022 While rst=1, the block SHALL hold seg=7'h7F, an=2'b11, d1_q=0, d0_q=0, cnt=0 and state=S_UNITS, asynchronously.
REQ-023 On the first edge after rst deasserts, seg SHALL be 7'h40 and an SHALL be 2'b10.
REQ-024 A mid-operation reset SHALL abandon the current slot and discard captured digits; no partial state SHALL survive.

Structure
REQ-025 Shared package bcd_pkg SHALL hold the state encoding (S_UNITS, S_TENS), SEG_BLANK=7'h7F, SEG_ERR=7'h06 and the ten digit constants.
REQ-026 A combinational sub-module bcd_to_seg (4-bit in, 7-bit out) SHALL implement decode, instantiated once and muxed by state.

Verification (REFRESH_DIV=4)
REQ-027 rst pulse mid-slot -> seg=7'h7F and an=2'b11 immediately; first post-reset edge gives seg=7'h40, an=2'b10.
REQ-028 load bcd1=1, bcd0=4 (9+5 carry case) -> S_UNITS: seg=7'h19, an=2'b10; after 4 cycles, S_TENS: seg=7'h79, an=2'b01; the pattern alternates every 4 cycles.
REQ-029 load bcd1=0, bcd0=8, blank_lz=1 -> the tens slot shows seg=7'h7F, an=2'b11; with blank_lz=0 the tens slot shows seg=7'h40, an=2'b01.
REQ-030 load bcd1=1, bcd0=15 (upstream invalid) -> the units slot shows seg=7'h06 ("E").
REQ-031 load asserted in the tick cycle with bcd1=3 -> the next slot (S_TENS) shows seg=7'h30 one cycle later.
REQ-032 load=0 while bcd inputs toggle randomly for 20 cycles -> seg shows only the previously captured digits.
